alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have port i_clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port i_rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port i_valid  input  1  upstream instruction valid.
REQ-005 SHALL have port o_ready  output  1  block can accept an instruction this cycle.
REQ-006 SHALL have ports i_instr  input  32  RV32I instruction word; i_pc  input  XLEN  its PC.
REQ-007 SHALL have ports i_rs1_data, i_rs2_data  input  XLEN  register-file read data.
REQ-008 SHALL have port o_valid  output  1  issued ALU request valid.
REQ-009 SHALL have port i_ready  input  1  ALU stage accepts the request.
REQ-010 SHALL have ports o_op_a, o_op_b  output  XLEN  ALU operands; o_alu_op  output  4  ALU opcode.
REQ-011 SHALL have ports o_rd_addr  output  5  destination register; o_illegal  output  1  undecodable instruction.
REQ-012 SHALL have port o_illegal_cnt  output  16  illegal-instruction count.

Function
REQ-013 SHALL encode o_alu_op as ADD=0, SUB=1, SLT=2, SLTU=3, XOR=4, OR=5, AND=6, SLL=7, SRL=8, SRA=9; values 10-15 never issued.
REQ-014 SHALL decode OP (0x33): funct3/funct7 to ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND; op_a=rs1, op_b=rs2; any other funct7 is illegal.
REQ-015 SHALL decode OP-IMM (0x13): op_a=rs1, op_b=sign-extended I-imm; SLLI/SRLI/SRAI use op_b=zero-extended shamt[4:0], with a funct7 other than 0x00/0x20 (0x20 only for SRAI) being illegal.
REQ-016 SHALL decode LUI (0x37): op_a=0, op_b={imm[31:12],12'b0}, ADD; AUIPC (0x17): op_a=i_pc, same op_b, ADD.
REQ-017 SHALL decode LOAD (0x03): rs1+I-imm, and STORE (0x23): rs1+S-imm, both ADD, with o_rd_addr=0 for STORE.
REQ-018 SHALL treat any other opcode as illegal: enqueue with o_illegal=1, op_a=op_b=0, alu_op=ADD, rd=0.
REQ-019 SHALL buffer decoded requests in a 2-entry FIFO; o_ready=1 iff occupancy<2, combinationally from registered occupancy only.
REQ-020 SHALL accept on i_valid&&o_ready; an entry accepted at edge N is presented at the outputs after edge N (1-cycle latency).
REQ-021 SHALL drive o_valid=1 iff occupancy>0 and pop on o_valid&&i_ready; outputs SHALL be held stable while o_valid&&!i_ready.
REQ-022 SHALL on simultaneous push and pop keep occupancy unchanged and preserve FIFO order; no push when full, even if popping that cycle.
REQ-023 SHALL wrap the 1-bit read/write pointers modulo 2.
REQ-024 SHALL sample i_instr, i_pc and register data only on an accepted cycle.

Reset
REQ-025 SHALL, on a rising edge with i_rst_n=0, clear occupancy and pointers, drive o_valid=0, o_op_a=o_op_b=0, o_alu_op=0, o_rd_addr=0, o_illegal=0, o_illegal_cnt=0.
REQ-026 SHALL discard buffered entries when reset is asserted mid-operation; o_ready=1 on the first cycle after reset deasserts.

Configuration
REQ-027 SHALL, when ALU_ISSUE_ILLEGAL_CNT_EN is defined, increment o_illegal_cnt by 1 on each accepted illegal instruction, saturating at 0xFFFF.
REQ-028 SHALL, when ALU_ISSUE_ILLEGAL_CNT_EN is undefined, hold o_illegal_cnt at 0 and include no counter logic.

Verification
REQ-029 SHALL cover: i_instr=0x002081B3 (add x3,x1,x2), rs1=5, rs2=7 -> next cycle o_valid=1, op_a=5, op_b=7, alu_op=0, rd=3.
REQ-030 SHALL cover: i_instr=0x40335293 (srai x5,x6,3), rs1=0x80000000 -> op_a=0x80000000, op_b=3, alu_op=9, rd=5.
REQ-031 SHALL cover: i_instr=0x123450B7 (lui x1,0x12345) -> op_a=0, op_b=0x12345000, alu_op=0, rd=1.
REQ-032 SHALL cover: i_ready=0, three back-to-back valids -> o_ready=0 after 2 accepts, third held; i_ready=1 -> three requests drained in order.
REQ-033 SHALL cover: i_instr=0xFFFFFFFF twice -> o_illegal=1 on each, o_illegal_cnt=2 with macro, 0 without.
REQ-034 SHALL cover: FIFO full, i_rst_n=0 for one edge -> o_valid=0, o_ready=1, all outputs 0 after that edge.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - RV32I ALU-class decode into a 2-entry issue FIFO
// Optional feature macro: ALU_ISSUE_ILLEGAL_CNT_EN (saturating illegal-instruction counter)
module alu_issue_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_op_a,
  output logic [XLEN-1:0] o_op_b,
  output logic [3:0]      o_alu_op,
  output logic [4:0]      o_rd_addr,
  output logic            o_illegal,
  output logic [15:0]     o_illegal_cnt
);

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLT  = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_AND  = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  typedef struct packed {
    logic            illegal;
    logic [4:0]      rd;
    logic [3:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } entry_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt;
  logic            unused_rs1_field;

  assign opcode = i_instr[6:0];
  assign funct3 = i_instr[14:12];
  assign funct7 = i_instr[31:25];
  assign imm_i  = XLEN'($signed(i_instr[31:20]));
  assign imm_s  = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
  assign imm_u  = XLEN'($signed({i_instr[31:12], 12'b0}));
  assign shamt  = XLEN'(i_instr[24:20]);
  // Register indices arrive pre-read as rs1/rs2 data; only rd is carried.
  assign unused_rs1_field = ^i_instr[19:15];

  logic            legal;
  logic [3:0]      dec_op;
  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;
  logic [4:0]      dec_rd;
  entry_t          dec;

  always_comb begin
    legal  = 1'b1;
    dec_op = ALU_ADD;
    dec_a  = i_rs1_data;
    dec_b  = i_rs2_data;
    dec_rd = i_instr[11:7];
    case (opcode)
      OPC_OP: begin
        if (funct7 == 7'h00) begin
          case (funct3)
            3'd0:    dec_op = ALU_ADD;
            3'd1:    dec_op = ALU_SLL;
            3'd2:    dec_op = ALU_SLT;
            3'd3:    dec_op = ALU_SLTU;
            3'd4:    dec_op = ALU_XOR;
            3'd5:    dec_op = ALU_SRL;
            3'd6:    dec_op = ALU_OR;
            default: dec_op = ALU_AND;
          endcase
        end else if (funct7 == 7'h20 && funct3 == 3'd0) begin
          dec_op = ALU_SUB;
        end else if (funct7 == 7'h20 && funct3 == 3'd5) begin
          dec_op = ALU_SRA;
        end else begin
          legal = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        dec_b = imm_i;
        case (funct3)
          3'd0: dec_op = ALU_ADD;
          3'd1: begin
            dec_op = ALU_SLL;
            dec_b  = shamt;
            legal  = (funct7 == 7'h00);
          end
          3'd2: dec_op = ALU_SLT;
          3'd3: dec_op = ALU_SLTU;
          3'd4: dec_op = ALU_XOR;
          3'd5: begin
            dec_b  = shamt;
            dec_op = (funct7 == 7'h20) ? ALU_SRA : ALU_SRL;
            legal  = (funct7 == 7'h00) || (funct7 == 7'h20);
          end
          3'd6:    dec_op = ALU_OR;
          default: dec_op = ALU_AND;
        endcase
      end
      OPC_LUI: begin
        dec_a = '0;
        dec_b = imm_u;
      end
      OPC_AUIPC: begin
        dec_a = i_pc;
        dec_b = imm_u;
      end
      OPC_LOAD:  dec_b = imm_i;
      OPC_STORE: begin
        dec_b  = imm_s;
        dec_rd = 5'd0;
      end
      default: legal = 1'b0;
    endcase

    dec.illegal = !legal;
    dec.rd      = legal ? dec_rd : 5'd0;
    dec.op      = legal ? dec_op : ALU_ADD;
    dec.a       = legal ? dec_a  : '0;
    dec.b       = legal ? dec_b  : '0;
  end

  entry_t     mem [2];
  logic [1:0] count;
  logic       wr_ptr;
  logic       rd_ptr;
  logic       push;
  logic       pop;

  assign o_ready = (count != 2'd2);
  assign o_valid = (count != 2'd0);
  assign push    = i_valid && o_ready;
  assign pop     = o_valid && i_ready;

  // Slots are cleared on reset so the presented head reads as all-zero.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign o_op_a    = mem[rd_ptr].a;
  assign o_op_b    = mem[rd_ptr].b;
  assign o_alu_op  = mem[rd_ptr].op;
  assign o_rd_addr = mem[rd_ptr].rd;
  assign o_illegal = mem[rd_ptr].illegal;

`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
  logic [15:0] illegal_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      illegal_cnt <= 16'd0;
    end else if (push && dec.illegal && illegal_cnt != 16'hFFFF) begin
      illegal_cnt <= illegal_cnt + 16'd1;
    end
  end

  assign o_illegal_cnt = illegal_cnt;
`else
  assign o_illegal_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - vector table, random model comparison and directed FIFO/reset sequences
module tb_alu_issue_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_instr;
  logic [31:0] i_pc;
  logic [31:0] i_rs1_data;
  logic [31:0] i_rs2_data;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_op_a;
  logic [31:0] o_op_b;
  logic [3:0]  o_alu_op;
  logic [4:0]  o_rd_addr;
  logic        o_illegal;
  logic [15:0] o_illegal_cnt;

  alu_issue_ctrl #(.XLEN(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_instr(i_instr), .i_pc(i_pc), .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_op_a(o_op_a), .o_op_b(o_op_b),
    .o_alu_op(o_alu_op), .o_rd_addr(o_rd_addr), .o_illegal(o_illegal),
    .o_illegal_cnt(o_illegal_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic        ill;
    logic [4:0]  rd;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    exp_t        e;
  } vec_t;

`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // funct3 -> ALU opcode for the funct7=0 register/immediate forms
  localparam logic [31:0] OPMAP = {4'd6, 4'd5, 4'd8, 4'd4, 4'd3, 4'd2, 4'd7, 4'd0};

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;
  exp_t q[$];
  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_head(input string tag, input exp_t e);
    check({tag, "_valid"}, 32'(o_valid), 32'd1);
    check({tag, "_op_a"}, o_op_a, e.a);
    check({tag, "_op_b"}, o_op_b, e.b);
    check({tag, "_alu_op"}, 32'(o_alu_op), 32'(e.op));
    check({tag, "_rd"}, 32'(o_rd_addr), 32'(e.rd));
    check({tag, "_illegal"}, 32'(o_illegal), 32'(e.ill));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(o_valid), 32'd0);
    check({tag, "_ready"}, 32'(o_ready), 32'd1);
    check({tag, "_op_a"}, o_op_a, 32'd0);
    check({tag, "_op_b"}, o_op_b, 32'd0);
    check({tag, "_alu_op"}, 32'(o_alu_op), 32'd0);
    check({tag, "_rd"}, 32'(o_rd_addr), 32'd0);
    check({tag, "_illegal"}, 32'(o_illegal), 32'd0);
    check({tag, "_cnt"}, 32'(o_illegal_cnt), 32'd0);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2);
    i_instr = ins; i_pc = pc; i_rs1_data = r1; i_rs2_data = r2;
  endtask

  function automatic exp_t mk(input logic ill, input logic [4:0] rd, input logic [3:0] op,
                              input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.ill = ill; e.rd = rd; e.op = op; e.a = a; e.b = b;
    return e;
  endfunction

  function automatic vec_t mkv(input logic [31:0] ins, input logic [31:0] pc,
                               input logic [31:0] r1, input logic [31:0] r2, input exp_t e);
    vec_t v;
    v.instr = ins; v.pc = pc; v.rs1 = r1; v.rs2 = r2; v.e = e;
    return v;
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic [31:0] r1, input logic [31:0] r2);
    logic [2:0]  f3 = ins[14:12];
    logic [6:0]  f7 = ins[31:25];
    logic [31:0] imm_i = {{20{ins[31]}}, ins[31:20]};
    logic [31:0] imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    logic [31:0] imm_u = {ins[31:12], 12'b0};
    logic [4:0]  rd = ins[11:7];
    logic [3:0]  base = OPMAP[f3 * 4 +: 4];
    exp_t bad = mk(1'b1, 5'd0, 4'd0, 32'd0, 32'd0);
    case (ins[6:0])
      7'h33: begin
        if (f7 == 7'h00) return mk(1'b0, rd, base, r1, r2);
        if (f7 == 7'h20 && f3 == 3'd0) return mk(1'b0, rd, 4'd1, r1, r2);
        if (f7 == 7'h20 && f3 == 3'd5) return mk(1'b0, rd, 4'd9, r1, r2);
        return bad;
      end
      7'h13: begin
        if (f3 != 3'd1 && f3 != 3'd5) return mk(1'b0, rd, base, r1, imm_i);
        if (f7 == 7'h00) return mk(1'b0, rd, base, r1, {27'd0, ins[24:20]});
        if (f7 == 7'h20 && f3 == 3'd5) return mk(1'b0, rd, 4'd9, r1, {27'd0, ins[24:20]});
        return bad;
      end
      7'h37: return mk(1'b0, rd, 4'd0, 32'd0, imm_u);
      7'h17: return mk(1'b0, rd, 4'd0, pc, imm_u);
      7'h03: return mk(1'b0, rd, 4'd0, r1, imm_i);
      7'h23: return mk(1'b0, 5'd0, 4'd0, r1, imm_s);
      default: return bad;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins = $urandom;
    int sel = $urandom_range(0, 6);
    int fsel = $urandom_range(0, 2);
    logic [6:0] opcs [6] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23};
    if (sel < 6) ins[6:0] = opcs[sel];
    if (fsel == 0) ins[31:25] = 7'h00;
    else if (fsel == 1) ins[31:25] = 7'h20;
    return ins;
  endfunction

  task automatic do_reset();
    i_rst_n = 1'b0;
    step();
    i_rst_n = 1'b1;
    q.delete();
    exp_cnt = 0;
  endtask

  initial begin
    i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    drive(32'd0, 32'd0, 32'd0, 32'd0);

    vecs[0]  = mkv(32'h002081B3, 0, 5, 7, mk(0, 3, 0, 5, 7));
    vecs[1]  = mkv(32'h40335293, 0, 32'h80000000, 9, mk(0, 5, 9, 32'h80000000, 3));
    vecs[2]  = mkv(32'h123450B7, 0, 11, 12, mk(0, 1, 0, 0, 32'h12345000));
    vecs[3]  = mkv(32'h40208133, 0, 20, 6, mk(0, 2, 1, 20, 6));
    vecs[4]  = mkv(32'h00001217, 32'h100, 1, 2, mk(0, 4, 0, 32'h100, 32'h1000));
    vecs[5]  = mkv(32'hFFF00093, 0, 3, 4, mk(0, 1, 0, 3, 32'hFFFFFFFF));
    vecs[6]  = mkv(32'h0020A423, 0, 32'h400, 5, mk(0, 0, 0, 32'h400, 8));
    vecs[7]  = mkv(32'hFFC0A283, 0, 32'h800, 5, mk(0, 5, 0, 32'h800, 32'hFFFFFFFC));
    vecs[8]  = mkv(32'hFFFFFFFF, 0, 1, 2, mk(1, 0, 0, 0, 0));
    vecs[9]  = mkv(32'h40311093, 0, 1, 2, mk(1, 0, 0, 0, 0));
    vecs[10] = mkv(32'h0020B1B3, 0, 9, 10, mk(0, 3, 3, 9, 10));
    vecs[11] = mkv(32'h022081B3, 0, 1, 2, mk(1, 0, 0, 0, 0));

    step(); step();
    check_all_zero("reset");
    i_rst_n = 1'b1;

    // Table: one instruction per cycle with the consumer always ready
    i_ready = 1'b1;
    foreach (vecs[k]) begin
      drive(vecs[k].instr, vecs[k].pc, vecs[k].rs1, vecs[k].rs2);
      i_valid = 1'b1;
      step();
      if (vecs[k].e.ill && CNT_EN) exp_cnt++;
      check_head($sformatf("vec%0d", k), vecs[k].e);
      check($sformatf("vec%0d_cnt", k), 32'(o_illegal_cnt), 32'(exp_cnt));
    end
    i_valid = 1'b0;
    step();
    check("drain_valid", 32'(o_valid), 32'd0);

    // Random traffic against the queue model
    for (int n = 0; n < 400; n++) begin
      bit acc, pop;
      exp_t e;
      drive(rand_instr(), $urandom, $urandom, $urandom);
      i_valid = ($urandom_range(0, 9) < 7);
      i_ready = ($urandom_range(0, 9) < 6);
      acc = i_valid && (q.size() < 2);
      pop = (q.size() > 0) && i_ready;
      e = ref_decode(i_instr, i_pc, i_rs1_data, i_rs2_data);
      step();
      if (pop) void'(q.pop_front());
      if (acc) begin
        q.push_back(e);
        if (e.ill && CNT_EN && exp_cnt < 65535) exp_cnt++;
      end
      check("rnd_ready", 32'(o_ready), 32'(q.size() < 2));
      check("rnd_valid", 32'(o_valid), 32'(q.size() > 0));
      if (q.size() > 0) check_head("rnd", q[0]);
      check("rnd_cnt", 32'(o_illegal_cnt), 32'(exp_cnt));
    end

    // Backpressure: two accepts fill the FIFO, third held, then in-order drain
    i_valid = 1'b0;
    do_reset();
    i_ready = 1'b0;
    i_valid = 1'b1;
    drive(32'h002080B3, 0, 1, 1); step();
    check("bp_ready1", 32'(o_ready), 32'd1);
    drive(32'h00208133, 0, 2, 2); step();
    check("bp_ready2", 32'(o_ready), 32'd0);
    drive(32'h002081B3, 0, 3, 3); step();
    check("bp_ready3", 32'(o_ready), 32'd0);
    check_head("bp_hold", mk(0, 1, 0, 1, 1));
    i_ready = 1'b1;
    step();
    check_head("bp_second", mk(0, 2, 0, 2, 2));
    check("bp_ready4", 32'(o_ready), 32'd1);
    step();
    i_valid = 1'b0;
    check_head("bp_third", mk(0, 3, 0, 3, 3));
    step();
    check("bp_empty", 32'(o_valid), 32'd0);

    // Two illegal instructions from a fresh reset
    do_reset();
    i_valid = 1'b1;
    drive(32'hFFFFFFFF, 0, 5, 5); step();
    check_head("ill1", mk(1, 0, 0, 0, 0));
    step();
    i_valid = 1'b0;
    check_head("ill2", mk(1, 0, 0, 0, 0));
    check("ill_cnt", 32'(o_illegal_cnt), CNT_EN ? 32'd2 : 32'd0);

    // Reset asserted while the FIFO is full
    i_ready = 1'b0;
    i_valid = 1'b1;
    drive(32'h002081B3, 0, 5, 7); step(); step();
    check("full_ready", 32'(o_ready), 32'd0);
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    step();
    check_all_zero("midrst");
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    step();
    check("post_rst_valid", 32'(o_valid), 32'd0);
    check("post_rst_ready", 32'(o_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
